fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Parametrised program-counter and fetch-control unit for the next-generation core. It replaces the fixed 6-bit PC/jump-LUT pair with several additions:
- configurable PC width;
- a runtime-writable jump table;
- absolute or PC-relative jump mode;
- a call/return address stack;
- stall support;
- a registered halt/Done state machine.

It drives the instruction ROM address and takes its control strobes from the decoder.

Parameters:
PC_W, 10, program counter width in bits; address space is 2^PC_W.
JT_DEPTH, 32, number of jump-table entries; index width JT_AW = clog2(JT_DEPTH).
RAS_DEPTH, 4, return-address stack depth (entries); must be ≥1.
JMODE, 0, 0 = jump-table entry is an absolute target; 1 = entry is a signed PC-relative offset.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Stall  input  1  hold PC and all control state this cycle
Jen  input  1  take jump through jump table
Call  input  1  take jump and push return address (implies Jen)
Ret  input  1  pop return address into PC
Halt  input  1  decoder halt strobe
Jptr  input  JT_AW  jump-table index
Jt_we  input  1  jump-table write enable
Jt_waddr  input  JT_AW  jump-table write index
Jt_wdata  input  PC_W  jump-table write data
PC  output  PC_W  current fetch address
Done  output  1  program finished (registered)
Ras_ovf  output  1  sticky: push attempted on full stack
Ras_unf  output  1  sticky: pop attempted on empty stack

Behaviour:
- Reset (Reset=0, asynchronous) sets:
  - PC=0, Done=0, state=RUN;
  - stack pointer=0, Ras_ovf=0, Ras_unf=0;
  - all jump-table entries to 0.
- States:
  - RUN: normal operation.
  - HALT: terminal. The only exit is reset. PC is frozen and Done=1.
- RUN next-PC priority, evaluated each rising edge:
  1. Stall=1 → PC and stack unchanged. Halt, Ret, Jen and Call are ignored that cycle.
  2. Halt=1 → state←HALT, PC unchanged. Done goes to 1 one cycle after Halt is sampled.
  3. Ret=1 → if stack non-empty, PC←top and pop. If empty, PC←PC+1 and Ras_unf←1.
  4. Call=1 → target computed as for Jen; PC←target. Push PC+1 if stack not full; if full, no push, jump still taken, Ras_ovf←1.
  5. Jen=1 → PC←target.
  6. Otherwise PC←PC+1.
- Target computation:
  - JMODE=0: target = JT[Jptr].
  - JMODE=1: target = PC + sign-extended JT[Jptr].
  - All arithmetic is modulo 2^PC_W. Increment wraps from 2^PC_W−1 to 0.
- Jump-table writes:
  - Occur on the rising edge when Jt_we=1, independent of Stall and state (a write is allowed in HALT).
  - A same-cycle read of the entry being written returns the old value.
- Return-address stack:
  - LIFO of PC_W-bit entries; pointer runs 0..RAS_DEPTH.
  - Ret and Call in the same cycle: Ret wins. Call is ignored and no push occurs.
- Sticky flags: Ras_ovf and Ras_unf clear only on reset.
- Latency: PC updates on the edge after the strobes are sampled. The ROM read of the new PC is combinational, outside this block.
- Reset mid-operation: all state returns to its reset values immediately. Stack contents are discarded; the pointer is 0.
- Unused Jptr codes (when JT_DEPTH is not a power of two) read as 0.

Decomposition:
- Shared package fetch_pkg, holding:
  - state enum {RUN, HALT};
  - JMODE_ABS / JMODE_REL constants;
  - the next-PC source select enum {HOLD, INC, JUMP, POP}.
- One natural sub-module, ret_stack:
  - parametrised by width and depth;
  - push/pop ports, top output, full/empty flags;
  - asynchronous active-low reset.
- The jump table and the FSM stay in fetch_sequencer.

Test Plan:
- Reset, then 1030 idle cycles (JMODE=0) → PC runs 0..1023, wraps to 0, reaches 6. Done=0.
- Write JT[3]=0x120; at PC=0x005 pulse Jen with Jptr=3 → next PC=0x120. Repeat with JMODE=1 and JT[3]=0x3FE (−2) at PC=0x005 → next PC=0x003.
- Call and return:
  - JT[5]=0x200; Call with Jptr=5 at PC=0x010 → PC=0x200.
  - Idle 2 cycles → PC=0x202.
  - Ret → PC=0x011. Flags stay 0.
- Stack faults:
  - 5 nested Calls (RAS_DEPTH=4) → Ras_ovf=1 after the 5th, jump still taken.
  - 4 Rets pop the 4 stored addresses in reverse order.
  - 5th Ret → PC+1, Ras_unf=1.
- Priority and halt:
  - Stall+Halt+Jen together → PC unchanged, state RUN.
  - Halt alone at PC=0x040 → Done=1 next cycle, PC stays 0x040 over 10 cycles despite Jen/Ret pulses.
  - Ret+Call together → pop wins.
- Reset mid-operation: assert Reset=0 asynchronously mid-cycle during HALT with a full stack → PC=0, Done=0, flags=0 immediately. After release the PC increments from 0, and a Ret sets Ras_unf.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
package fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam int JMODE_ABS = 0;
    localparam int JMODE_REL = 1;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        INC  = 2'd1,
        JUMP = 2'd2,
        POP  = 2'd3
    } pc_src_t;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO with full/empty flags
module ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    import fetch_pkg::*;

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] wr_idx;

    // ptr counts stored entries; top sits one below it
    assign full    = (ptr == PW'(DEPTH));
    assign empty   = (ptr == '0);
    assign top_idx = IW'(ptr - PW'(1));
    assign wr_idx  = IW'(ptr);
    assign top     = empty ? '0 : mem[top_idx];

    // Pop has precedence; both are ignored when they would over/underflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            ptr         <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, jump table, call stack and halt control
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int JT_DEPTH  = 32,
    parameter int RAS_DEPTH = 4,
    parameter int JMODE     = 0,
    localparam int JT_AW    = (JT_DEPTH > 1) ? $clog2(JT_DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Jen,
    input  logic             Call,
    input  logic             Ret,
    input  logic             Halt,
    input  logic [JT_AW-1:0] Jptr,
    input  logic             Jt_we,
    input  logic [JT_AW-1:0] Jt_waddr,
    input  logic [PC_W-1:0]  Jt_wdata,
    output logic [PC_W-1:0]  PC,
    output logic             Done,
    output logic             Ras_ovf,
    output logic             Ras_unf
);

    state_t          state, state_next;
    pc_src_t         src;
    logic [PC_W-1:0] pc, pc_next, pc_inc, target, jt_rd, ras_top;
    logic            ovf, unf, set_ovf, set_unf;
    logic            push, pop, ras_full, ras_empty;
    logic [PC_W-1:0] jt [JT_DEPTH];

    assign pc_inc = pc + PC_W'(1);

    // Jump-table read; codes past the last entry read as zero
    always_comb begin
        jt_rd = '0;
        if (int'(Jptr) < JT_DEPTH) begin
            jt_rd = jt[Jptr];
        end
    end

    // Relative mode: a PC_W-bit add modulo 2^PC_W is the sign-extended offset add
    assign target = (JMODE == JMODE_REL) ? (pc + jt_rd) : jt_rd;

    // Jump-table writes ignore Stall and state; reads this cycle see the old entry
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < JT_DEPTH; i++) begin
                jt[i] <= '0;
            end
        end else if (Jt_we && (int'(Jt_waddr) < JT_DEPTH)) begin
            jt[Jt_waddr] <= Jt_wdata;
        end
    end

    // Next-state and next-PC source in priority order Stall > Halt > Ret > Call > Jen
    always_comb begin
        state_next = state;
        src        = HOLD;
        push       = 1'b0;
        pop        = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        if (state == RUN && !Stall) begin
            if (Halt) begin
                state_next = HALT;
            end else if (Ret) begin
                if (!ras_empty) begin
                    src = POP;
                    pop = 1'b1;
                end else begin
                    src     = INC;
                    set_unf = 1'b1;
                end
            end else if (Call) begin
                src = JUMP;
                if (!ras_full) begin
                    push = 1'b1;
                end else begin
                    set_ovf = 1'b1;
                end
            end else if (Jen) begin
                src = JUMP;
            end else begin
                src = INC;
            end
        end
    end

    // Next-PC multiplexer
    always_comb begin
        pc_next = pc;
        case (src)
            HOLD:    pc_next = pc;
            INC:     pc_next = pc_inc;
            JUMP:    pc_next = target;
            POP:     pc_next = ras_top;
            default: pc_next = pc;
        endcase
    end

    // State, PC and sticky stack-fault flags
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= RUN;
            pc    <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (set_ovf) ovf <= 1'b1;
            if (set_unf) unf <= 1'b1;
        end
    end

    ret_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ret_stack (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    assign PC      = pc;
    assign Done    = (state == HALT);
    assign Ras_ovf = ovf;
    assign Ras_unf = unf;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer in both jump modes
module tb_fetch_sequencer;

    localparam int PC_W      = 10;
    localparam int JT_DEPTH  = 32;
    localparam int RAS_DEPTH = 4;
    localparam int MODN      = 1 << PC_W;

    // control word: {reset_n, stall, halt, jen, call, ret}
    localparam logic [5:0] R = 6'b100000;
    localparam logic [5:0] S = 6'b010000;
    localparam logic [5:0] H = 6'b001000;
    localparam logic [5:0] J = 6'b000100;
    localparam logic [5:0] C = 6'b000010;
    localparam logic [5:0] T = 6'b000001;

    logic       clk = 1'b0;
    logic       rst_n, stall, halt, jen, call, ret, we;
    logic [4:0] jptr, waddr;
    logic [9:0] wdata0, wdata1;
    logic [9:0] pc0, pc1;
    logic       done0, done1, ovf0, ovf1, unf0, unf1;

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_W(PC_W), .JT_DEPTH(JT_DEPTH), .RAS_DEPTH(RAS_DEPTH), .JMODE(0)) u0 (
        .Clk(clk), .Reset(rst_n), .Stall(stall), .Jen(jen), .Call(call), .Ret(ret), .Halt(halt),
        .Jptr(jptr), .Jt_we(we), .Jt_waddr(waddr), .Jt_wdata(wdata0),
        .PC(pc0), .Done(done0), .Ras_ovf(ovf0), .Ras_unf(unf0)
    );

    fetch_sequencer #(.PC_W(PC_W), .JT_DEPTH(JT_DEPTH), .RAS_DEPTH(RAS_DEPTH), .JMODE(1)) u1 (
        .Clk(clk), .Reset(rst_n), .Stall(stall), .Jen(jen), .Call(call), .Ret(ret), .Halt(halt),
        .Jptr(jptr), .Jt_we(we), .Jt_waddr(waddr), .Jt_wdata(wdata1),
        .PC(pc1), .Done(done1), .Ras_ovf(ovf1), .Ras_unf(unf1)
    );

    int checks = 0;
    int errors = 0;

    // reference model: index 0 = absolute mode, 1 = relative mode
    int m_pc   [2];
    bit m_halt [2];
    bit m_ovf  [2];
    bit m_unf  [2];
    int m_jt   [2][JT_DEPTH];
    int m_stk  [2][RAS_DEPTH];
    int m_sp   [2];

    logic [12:0] q0 [$];
    logic [12:0] q1 [$];
    logic [12:0] imm0 [$];
    logic [12:0] imm1 [$];
    event imm_ev;

    function automatic void cmp(string nm, logic [12:0] e, logic [12:0] a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got pc=%0h done=%0b ovf=%0b unf=%0b want pc=%0h done=%0b ovf=%0b unf=%0b",
                     nm, $time, a[12:3], a[2], a[1], a[0], e[12:3], e[2], e[1], e[0]);
        end
    endfunction

    function automatic void model_step(int k, int wd);
        int tgt, inc;
        if (!rst_n) begin
            m_pc[k] = 0; m_halt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_sp[k] = 0;
            for (int i = 0; i < JT_DEPTH; i++) m_jt[k][i] = 0;
            return;
        end
        tgt = (k == 0) ? m_jt[k][jptr] : (m_pc[k] + m_jt[k][jptr]) % MODN;
        inc = (m_pc[k] + 1) % MODN;
        if (!m_halt[k] && !stall) begin
            if (halt) begin
                m_halt[k] = 1;
            end else if (ret) begin
                if (m_sp[k] > 0) begin
                    m_sp[k]--;
                    m_pc[k] = m_stk[k][m_sp[k]];
                end else begin
                    m_pc[k]  = inc;
                    m_unf[k] = 1;
                end
            end else if (call) begin
                if (m_sp[k] < RAS_DEPTH) begin
                    m_stk[k][m_sp[k]] = inc;
                    m_sp[k]++;
                end else begin
                    m_ovf[k] = 1;
                end
                m_pc[k] = tgt;
            end else if (jen) begin
                m_pc[k] = tgt;
            end else begin
                m_pc[k] = inc;
            end
        end
        if (we) m_jt[k][waddr] = wd;
    endfunction

    function automatic logic [12:0] expv(int k);
        logic [9:0] p;
        p = m_pc[k][9:0];
        return {p, m_halt[k], m_ovf[k], m_unf[k]};
    endfunction

    task automatic cyc(input logic [5:0] ctl, input int p = 0, input bit w = 0,
                       input int wa = 0, input int wd0 = 0, input int wd1 = 0);
        @(negedge clk);
        {rst_n, stall, halt, jen, call, ret} = ctl;
        jptr = p[4:0]; we = w; waddr = wa[4:0];
        wdata0 = wd0[9:0]; wdata1 = wd1[9:0];
        model_step(0, wd0 % MODN);
        model_step(1, wd1 % MODN);
        q0.push_back(expv(0));
        q1.push_back(expv(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(R);
    endtask

    task automatic goto0(input int t);
        int n;
        n = 0;
        while (m_pc[0] != t && n < 2000) begin
            cyc(R);
            n++;
        end
        if (m_pc[0] != t) begin
            checks++;
            errors++;
            $display("FAIL goto_pc got=%0h want=%0h", m_pc[0], t);
        end
    endtask

    function automatic bit pr(int n);
        return ($urandom_range(n - 1) == 0);
    endfunction

    // monitor: compare each DUT output against the oldest queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) cmp("abs", q0.pop_front(), {pc0, done0, ovf0, unf0});
            if (q1.size() > 0) cmp("rel", q1.pop_front(), {pc1, done1, ovf1, unf1});
        end
    end

    // monitor for asynchronous reset effects between clock edges
    initial begin
        forever begin
            @(imm_ev);
            if (imm0.size() > 0) cmp("abs_async_rst", imm0.pop_front(), {pc0, done0, ovf0, unf0});
            if (imm1.size() > 0) cmp("rel_async_rst", imm1.pop_front(), {pc1, done1, ovf1, unf1});
        end
    end

    initial begin
        rst_n = 1'b0; stall = 0; halt = 0; jen = 0; call = 0; ret = 0; we = 0;
        jptr = '0; waddr = '0; wdata0 = '0; wdata1 = '0;

        // reset and full wrap of the PC
        cyc(6'b0); cyc(6'b0);
        idle(1030);

        // jump through table in both modes
        cyc(6'b0);
        cyc(R, 0, 1, 3, 'h120, 'h3FE);
        goto0(5);
        cyc(R | J, 3);
        idle(2);

        // call, idle, return
        cyc(6'b0);
        cyc(R, 0, 1, 5, 'h200, 'h200);
        goto0('h10);
        cyc(R | C, 5);
        idle(2);
        cyc(R | T);
        idle(1);

        // nested calls overflow, then drain and underflow
        cyc(6'b0);
        cyc(R, 0, 1, 7, 'h100, 'h100);
        for (int i = 0; i < 5; i++) begin
            cyc(R | C, 7);
            idle(1);
        end
        for (int i = 0; i < 5; i++) cyc(R | T);

        // priority: stall masks everything, ret beats call
        cyc(R | S | H | J, 3);
        cyc(R | C, 7);
        idle(1);
        cyc(R | T | C, 7);
        idle(1);

        // halt freezes PC; table writes still land
        cyc(6'b0);
        goto0('h40);
        cyc(R | H);
        for (int i = 0; i < 10; i++) cyc((i % 2 == 0) ? (R | J) : (R | T), 3, (i == 4), 9, 'h55, 'h55);

        // asynchronous reset during halt with a full stack
        cyc(6'b0);
        cyc(R, 0, 1, 2, 'h300, 'h010);
        for (int i = 0; i < 4; i++) cyc(R | C, 2);
        cyc(R | H);
        idle(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        imm0.push_back(13'h0);
        imm1.push_back(13'h0);
        ->imm_ev;
        cyc(6'b0);
        idle(3);
        cyc(R | T);
        idle(1);

        // randomized traffic
        cyc(6'b0);
        for (int i = 0; i < 600; i++) begin
            logic [5:0] ctl;
            if ((m_halt[0] && pr(4)) || pr(200)) ctl = 6'b0;
            else ctl = {1'b1, pr(8), pr(100), pr(6), pr(8), pr(8)};
            cyc(ctl, $urandom_range(31), pr(4), $urandom_range(31),
                $urandom_range(MODN - 1), $urandom_range(MODN - 1));
        end

        @(posedge clk);
        #3;
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d want=0", q0.size() + q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
